pipeline_ctrl_n: RTL and testbench

Parametrised pipeline stall/flush controller for the in-order multi-issue core: `STAGES` stages, `ISSUE` execute lanes and a `FETCH_NUM`-entry fetch window. It merges per-stage stall requests, exception flushes and branch-mispredict flushes into per-stage stall/flush vectors. A registered wait-for-delay-slot FSM holds a mispredicted branch until its delay slot has been fetched. Saturating per-stage stall-cycle counters feed the performance monitor.

---
 rtl/pipeline_ctrl_n.sv | 80 ++++++++
 tb/tb_pipeline_ctrl_n.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_n.sv
// pipeline_ctrl_n: merges stall/flush requests, holds mispredicts until the delay slot is fetched, and counts stall cycles per stage.
module pipeline_ctrl_n #(
  parameter int STAGES    = 4,
  parameter int EX_IDX    = 2,
  parameter int FE_FLUSH  = 2,
  parameter int ISSUE     = 2,
  parameter int FETCH_NUM = 4,
  parameter int RB_W      = 64,
  parameter int CNT_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STAGES-1:0]       stall_req,
  input  logic                    exc_valid,
  input  logic                    exc_alpha_taken,
  input  logic [ISSUE-1:0]        exec_valid,
  input  logic [ISSUE-1:0]        br_valid,
  input  logic [ISSUE-1:0]        br_mispredict,
  input  logic [ISSUE*RB_W-1:0]   br_info,
  input  logic [FETCH_NUM-1:0]    fetch_valid,
  input  logic                    cnt_clr,
  output logic [STAGES-1:0]       stall,
  output logic [STAGES-1:0]       flush,
  output logic [RB_W-1:0]         resolved_branch,
  output logic                    resolved_valid,
  output logic                    delayslot_not_exec,
  output logic                    hold_resolved_branch,
  output logic                    waiting,
  output logic [STAGES*CNT_W-1:0] stall_cnt
);
  typedef enum logic {RUN, WAIT_DS} state_t;
  localparam logic [STAGES-1:0] ONES    = '1;
  localparam logic [STAGES-1:0] EX_MASK = ONES >> (STAGES-1-EX_IDX);
  localparam logic [STAGES-1:0] FE_MASK = ONES >> (STAGES-FE_FLUSH);
  state_t state, state_n;
  logic [RB_W-1:0] rb_q, sel_info;
  logic [STAGES-1:0] req_mask;
  logic [ISSUE-1:0] mp;
  logic ds_out, fetch_avail, enter, wait_stall, in_wait;
  always_comb begin
    mp = br_valid & br_mispredict;
    sel_info = '0;
    for (int i = 0; i < ISSUE; i++)
      if (br_valid[i]) sel_info = br_info[i*RB_W +: RB_W];
    // a lane's delay slot lies outside the bundle when the next-younger lane is empty
    ds_out = |(mp & ~{1'b0, exec_valid[ISSUE-1:1]});
    for (int k = 0; k < STAGES; k++)
      req_mask[k] = |(stall_req >> k);
    fetch_avail = |fetch_valid;
    in_wait = state == WAIT_DS;
    enter = ~in_wait & ds_out & ~fetch_avail & ~exc_valid;
    wait_stall = in_wait ? ~fetch_avail & ~exc_valid : enter;
    stall = rst ? '1 : |stall_req ? req_mask : wait_stall ? EX_MASK : '0;
    flush = rst ? '0 : exc_valid ? {exc_alpha_taken, {(STAGES-1){1'b1}}} :
            (~in_wait & |mp & ~ds_out) ? FE_MASK : '0;
    state_n = rst ? RUN : in_wait ? ((fetch_avail | exc_valid) ? RUN : WAIT_DS) : (enter ? WAIT_DS : RUN);
    resolved_valid = ~rst & (in_wait ? fetch_avail & ~exc_valid : |br_valid & ~enter);
    resolved_branch = resolved_valid ? (in_wait ? rb_q : sel_info) : '0;
    delayslot_not_exec = ~rst & (in_wait | ds_out);
    waiting = ~rst & in_wait;
    hold_resolved_branch = |stall[STAGES-1:EX_IDX];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      rb_q <= '0;
    end else begin
      state <= state_n;
      if (enter) rb_q <= sel_info;
    end
  end
  logic [CNT_W-1:0] cnt [STAGES];
  for (genvar k = 0; k < STAGES; k++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst | cnt_clr) cnt[k] <= '0;
      else if (stall[k] & ~&cnt[k]) cnt[k] <= cnt[k] + 1'b1;
    end
    assign stall_cnt[k*CNT_W +: CNT_W] = cnt[k];
  end
endmodule

// File: tb/tb_pipeline_ctrl_n.sv
// tb_pipeline_ctrl_n: directed and random stimulus checked against a behavioural model of the stall/flush controller.
module tb_pipeline_ctrl_n;
  logic clk = 0;
  logic rst;
  logic [3:0] stall_req;
  logic exc_valid, exc_alpha_taken;
  logic [1:0] exec_valid, br_valid, br_mispredict;
  logic [127:0] br_info;
  logic [3:0] fetch_valid;
  logic cnt_clr;
  logic [3:0] stall, flush;
  logic [63:0] resolved_branch;
  logic resolved_valid, delayslot_not_exec, hold_resolved_branch, waiting;
  logic [15:0] stall_cnt;
  int vecs = 0, errs = 0;
  bit m_wait = 0;
  logic [63:0] m_rb = '0;
  int m_cnt [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  pipeline_ctrl_n #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .exc_valid(exc_valid),
    .exc_alpha_taken(exc_alpha_taken), .exec_valid(exec_valid), .br_valid(br_valid),
    .br_mispredict(br_mispredict), .br_info(br_info), .fetch_valid(fetch_valid),
    .cnt_clr(cnt_clr), .stall(stall), .flush(flush), .resolved_branch(resolved_branch),
    .resolved_valid(resolved_valid), .delayslot_not_exec(delayslot_not_exec),
    .hold_resolved_branch(hold_resolved_branch), .waiting(waiting), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [1:0] mp;
    logic ds, fa, ent, wc, erv, edn, ew;
    logic [63:0] sel, erb;
    logic [3:0] es, ef;
    int hk;
    mp = br_valid & br_mispredict;
    sel = '0;
    for (int i = 0; i < 2; i++) if (br_valid[i]) sel = br_info[i*64 +: 64];
    ds = mp[1] || (mp[0] && !exec_valid[1]);
    fa = fetch_valid != 0;
    ent = !m_wait && ds && !fa && !exc_valid;
    wc = m_wait ? (!fa && !exc_valid) : ent;
    hk = -1;
    for (int k = 0; k < 4; k++) if (stall_req[k]) hk = k;
    if (rst) es = 4'hF;
    else if (hk >= 0) es = 4'((1 << (hk + 1)) - 1);
    else if (wc) es = 4'b0111;
    else es = 4'b0000;
    if (rst) ef = 4'b0000;
    else if (exc_valid) ef = {exc_alpha_taken, 3'b111};
    else if (!m_wait && mp != 0 && !ds) ef = 4'b0011;
    else ef = 4'b0000;
    if (rst) erv = 0;
    else if (m_wait) erv = fa && !exc_valid;
    else erv = br_valid != 0 && !ent;
    erb = !erv ? 64'd0 : m_wait ? m_rb : sel;
    edn = !rst && (m_wait || ds);
    ew = !rst && m_wait;
    chk("stall", stall, es);
    chk("flush", flush, ef);
    chk("resolved_valid", resolved_valid, erv);
    chk("resolved_branch", resolved_branch, erb);
    chk("delayslot_not_exec", delayslot_not_exec, edn);
    chk("waiting", waiting, ew);
    chk("hold_resolved_branch", hold_resolved_branch, es[3] | es[2]);
    for (int k = 0; k < 4; k++) chk($sformatf("stall_cnt%0d", k), stall_cnt[k*4 +: 4], m_cnt[k]);
    for (int k = 0; k < 4; k++)
      if (rst || cnt_clr) m_cnt[k] = 0;
      else if (es[k] && m_cnt[k] < 15) m_cnt[k]++;
    if (rst) begin
      m_wait = 0;
      m_rb = '0;
    end else if (m_wait) begin
      if (fa || exc_valid) m_wait = 0;
    end else if (ent) begin
      m_wait = 1;
      m_rb = sel;
    end
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic fin();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    fin();
  endtask

  task automatic clear_br();
    br_valid = '0;
    br_mispredict = '0;
    br_info = '0;
  endtask

  initial begin
    rst = 1; stall_req = '0; exc_valid = 0; exc_alpha_taken = 0; exec_valid = '0;
    clear_br(); fetch_valid = '0; cnt_clr = 0;
    settle();
    chk("rst_stall", stall, 4'hF);
    chk("rst_flush", flush, 4'h0);
    chk("rst_hold", hold_resolved_branch, 1'b1);
    fin();
    tick();
    rst = 0;
    stall_req = 4'b0010;
    settle(); chk("tp_stall_0010", stall, 4'b0011); fin();
    stall_req = 4'b1010;
    settle(); chk("tp_stall_1010", stall, 4'b1111); chk("tp_hold", hold_resolved_branch, 1'b1); fin();
    stall_req = '0;
    exc_valid = 1;
    settle(); chk("tp_exc_flush", flush, 4'b0111); fin();
    exc_alpha_taken = 1;
    settle(); chk("tp_exc_alpha", flush, 4'b1111); fin();
    exc_valid = 0; exc_alpha_taken = 0;
    br_valid = 2'b01; br_mispredict = 2'b01; exec_valid = 2'b11; br_info[63:0] = 64'h1234;
    settle(); chk("tp_inb_flush", flush, 4'b0011); chk("tp_inb_rv", resolved_valid, 1'b1); fin();
    clear_br();
    settle(); chk("tp_inb_nowait", waiting, 1'b0); fin();
    br_valid = 2'b10; br_mispredict = 2'b10; br_info[127:64] = 64'hABCD;
    settle(); chk("tp_ds_detect_stall", stall, 4'b0111); fin();
    for (int c = 0; c < 2; c++) begin
      settle(); chk("tp_ds_wait", waiting, 1'b1); chk("tp_ds_stall", stall, 4'b0111); fin();
    end
    fetch_valid = 4'b0001;
    settle();
    chk("tp_ds_rel_wait", waiting, 1'b1);
    chk("tp_ds_rel_rb", resolved_branch, 64'hABCD);
    chk("tp_ds_rel_rv", resolved_valid, 1'b1);
    fin();
    clear_br();
    settle(); chk("tp_ds_run", waiting, 1'b0); fin();
    fetch_valid = '0;
    br_valid = 2'b10; br_mispredict = 2'b10; br_info[127:64] = 64'h5555;
    tick();
    tick();
    exc_valid = 1;
    settle(); chk("tp_wexc_flush", flush, 4'b0111); chk("tp_wexc_rv", resolved_valid, 1'b0); fin();
    exc_valid = 0; clear_br();
    settle(); chk("tp_wexc_run", waiting, 1'b0); chk("tp_wexc_noemit", resolved_valid, 1'b0); fin();
    rst = 1; tick(); rst = 0;
    stall_req = 4'b0001;
    repeat (20) tick();
    settle(); chk("tp_cnt_sat", stall_cnt[3:0], 4'd15); fin();
    stall_req = '0; cnt_clr = 1;
    tick();
    cnt_clr = 0;
    settle(); chk("tp_cnt_clr", stall_cnt[3:0], 4'd0); fin();
    for (int n = 0; n < 600; n++) begin
      rst = $urandom_range(0, 49) == 0;
      cnt_clr = $urandom_range(0, 39) == 0;
      stall_req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      exc_valid = $urandom_range(0, 9) == 0;
      exc_alpha_taken = 1'($urandom);
      exec_valid = 2'($urandom);
      br_valid = 2'($urandom);
      br_mispredict = 2'($urandom);
      br_info = {$urandom, $urandom, $urandom, $urandom};
      fetch_valid = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
